// File: rtl/arrow_scheduler_if.sv
// rtl/arrow_scheduler_if.sv - control/key inputs and renderer/score outputs of arrow_scheduler
// master: game-side driver (frame_tick, start, key_valid, key_code); reads lane bounds and counters
// slave : arrow_scheduler; consumes pulses, drives lane bounds, visible bits, score, miss, game_over
interface arrow_scheduler_if;
   logic       frame_tick;
   logic       start;
   logic       key_valid;
   logic [2:0] key_code;
   logic [9:0] d_top, d_bottom, u_top, u_bottom, l_top, l_bottom, r_top, r_bottom;
   logic       d_visible, u_visible, l_visible, r_visible;
   logic [7:0] score;
   logic [7:0] miss;
   logic       game_over;

   modport master (
      output frame_tick, start, key_valid, key_code,
      input  d_top, d_bottom, u_top, u_bottom, l_top, l_bottom, r_top, r_bottom,
      input  d_visible, u_visible, l_visible, r_visible, score, miss, game_over
   );

   modport slave (
      input  frame_tick, start, key_valid, key_code,
      output d_top, d_bottom, u_top, u_bottom, l_top, l_bottom, r_top, r_bottom,
      output d_visible, u_visible, l_visible, r_visible, score, miss, game_over
   );
endinterface

// File: rtl/arrow_scheduler.sv
// rtl/arrow_scheduler.sv - four-lane arrow spawn/scroll/judge sequencer with score and miss counters
// Ports: clk, rst_n (async active-low); bus (arrow_scheduler_if.slave):
//   in : frame_tick, start, key_valid, key_code[2:0]
//   out: {d,u,l,r}_{top,bottom}[9:0], {d,u,l,r}_visible, score[7:0], miss[7:0], game_over
// Lane index: 0 down, 1 up, 2 left, 3 right.
module arrow_scheduler #(
   parameter int         ARROW_H   = 80,
   parameter int         Y_START   = 31,
   parameter int         Y_END     = 511,
   parameter int         STEP      = 2,
   parameter int         WIN_TOP   = 205,
   parameter int         WIN_BOT   = 290,
   parameter int         SPAWN_GAP = 60,
   parameter int         MAX_MISS  = 8,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input logic             clk,
   input logic             rst_n,
   arrow_scheduler_if.slave bus
);
   localparam int         CW = $clog2(SPAWN_GAP + 1);
   localparam logic [9:0] Y0 = 10'(Y_START);
   localparam logic [9:0] AH = 10'(ARROW_H);

   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      lfsr_q, lfsr_d;
   logic [3:0][9:0] y_q, y_d, top_q, top_d;
   logic [3:0]      live_q, live_d;
   logic [7:0]      score_q, score_d, miss_q, miss_d;
   logic            game_over_q, game_over_d;

   logic            key_ok;
   logic [1:0]      key_lane, spawn_lane;
   logic [3:0]      hit;
   logic [2:0]      n_retire;
   logic [8:0]      miss_sum;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lfsr_d     = lfsr_q;
      y_d        = y_q;
      live_d     = live_q;
      score_d    = score_q;
      miss_d     = miss_q;
      key_ok     = 1'b0;
      key_lane   = 2'd0;
      spawn_lane = 2'd0;
      hit        = 4'b0;
      n_retire   = 3'd0;
      miss_sum   = 9'd0;
      case (state_q)
         PLAY: begin
            key_ok = bus.key_valid && !bus.key_code[2];
            case (bus.key_code[1:0])
               2'd0:    key_lane = 2'd2;
               2'd1:    key_lane = 2'd3;
               2'd2:    key_lane = 2'd1;
               default: key_lane = 2'd0;
            endcase
            // A hit on a lane takes precedence over its move/retire this cycle.
            for (int i = 0; i < 4; i++) begin
               hit[i] = key_ok && (key_lane == 2'(i)) && live_q[i] &&
                        (y_q[i] >= 10'(WIN_TOP)) && (y_q[i] <= 10'(WIN_BOT));
               if (hit[i]) begin
                  live_d[i] = 1'b0;
                  y_d[i]    = Y0;
               end else if (bus.frame_tick && live_q[i]) begin
                  if ({1'b0, y_q[i]} + 11'(ARROW_H + STEP) <= 11'(Y_END)) begin
                     y_d[i] = y_q[i] + 10'(STEP);
                  end else begin
                     live_d[i] = 1'b0;
                     y_d[i]    = Y0;
                     n_retire  = n_retire + 3'd1;
                  end
               end
            end
            if ((|hit) && (score_q != 8'hFF)) score_d = score_q + 8'd1;
            // Spawn only into a lane that was empty at the start of the cycle, so a
            // lane freed by a hit/retire this cycle is never refilled immediately.
            if (bus.frame_tick) begin
               if (cnt_q == CW'(SPAWN_GAP - 1)) begin
                  cnt_d      = '0;
                  lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                  spawn_lane = lfsr_d[1:0];
                  if (!live_q[spawn_lane]) begin
                     live_d[spawn_lane] = 1'b1;
                     y_d[spawn_lane]    = Y0;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            miss_sum = {1'b0, miss_q} + 9'(n_retire);
            miss_d   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
            if (miss_d >= 8'(MAX_MISS)) state_d = OVER;
         end
         default: begin
            if (bus.start) begin
               state_d = PLAY;
               cnt_d   = '0;
               y_d     = {4{Y0}};
               live_d  = 4'b0;
               score_d = 8'd0;
               miss_d  = 8'd0;
            end
         end
      endcase
      for (int i = 0; i < 4; i++) top_d[i] = y_d[i] + AH;
      game_over_d = (state_d == OVER);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         lfsr_q      <= LFSR_SEED;
         y_q         <= {4{Y0}};
         top_q       <= {4{Y0 + AH}};
         live_q      <= 4'b0;
         score_q     <= 8'd0;
         miss_q      <= 8'd0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lfsr_q      <= lfsr_d;
         y_q         <= y_d;
         top_q       <= top_d;
         live_q      <= live_d;
         score_q     <= score_d;
         miss_q      <= miss_d;
         game_over_q <= game_over_d;
      end
   end

   assign bus.d_bottom  = y_q[0];
   assign bus.u_bottom  = y_q[1];
   assign bus.l_bottom  = y_q[2];
   assign bus.r_bottom  = y_q[3];
   assign bus.d_top     = top_q[0];
   assign bus.u_top     = top_q[1];
   assign bus.l_top     = top_q[2];
   assign bus.r_top     = top_q[3];
   assign bus.d_visible = live_q[0];
   assign bus.u_visible = live_q[1];
   assign bus.l_visible = live_q[2];
   assign bus.r_visible = live_q[3];
   assign bus.score     = score_q;
   assign bus.miss      = miss_q;
   assign bus.game_over = game_over_q;
endmodule
